// File: rtl/prime_disp_pkg.sv
// Shared types and ASCII constants for the prime-table LCD scroller.
// States, power-on row text and the nibble-to-hex helper live here.
package prime_disp_pkg;

   typedef enum logic [2:0] {
      S_WAIT_RDY,
      S_IDLE,
      S_READ,
      S_WAIT,
      S_COMMIT
   } state_t;

   localparam logic [127:0] ROW_A_RST = "Press BTN3 to   ";
   localparam logic [127:0] ROW_B_RST = "show a message..";
   localparam logic [55:0]  LINE_PFX  = "Prime #";
   localparam logic [31:0]  LINE_MID  = " is ";
   localparam logic [7:0]   ASCII_0   = 8'h30;
   localparam logic [7:0]   ASCII_A10 = 8'h37;  // 'A' - 10

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (ASCII_0 + {4'h0, nib}) : (ASCII_A10 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/prime_line_fmt.sv
// Builds the 16-character "Prime #hh is vvv" line from a table index and value.
module prime_line_fmt
   import prime_disp_pkg::*;
(
   input  logic [7:0]   idx,
   input  logic [9:0]   val,
   output logic [127:0] line
);

   // Values are < 1024, so the leading digit is only ever 0..3.
   assign line = {LINE_PFX,
                  hex_ascii(idx[7:4]), hex_ascii(idx[3:0]),
                  LINE_MID,
                  ASCII_0 + {6'd0, val[9:8]},
                  hex_ascii(val[7:4]), hex_ascii(val[3:0])};

endmodule

// File: rtl/prime_scroll_ctrl.sv
// Prime-table to LCD-row scroll sequencer with direction toggle.
// Optional build macro SCROLL_PAUSE_EN adds a pause_toggle input that freezes the tick.
module prime_scroll_ctrl
   import prime_disp_pkg::*;
#(
   parameter int TICK_CYCLES = 70000000,
   parameter int IDX_W       = 8,
   parameter int VAL_W       = 10,
   parameter int RD_LAT      = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             table_ready,
   input  logic [IDX_W-1:0] table_count,
   input  logic             dir_toggle,
`ifdef SCROLL_PAUSE_EN
   input  logic             pause_toggle,
`endif
   output logic             rd_en,
   output logic [IDX_W-1:0] rd_addr,
   input  logic [VAL_W-1:0] rd_data,
   output logic [127:0]     row_A,
   output logic [127:0]     row_B,
   output logic             busy
);

   localparam int               TCW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TCW-1:0]   TICK_LAST = TCW'(TICK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [1:0]       WAIT_LAST = 2'(RD_LAT - 1);

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i,
                                                 input logic [IDX_W-1:0] c);
      return (i == c) ? IDX_ONE : i + IDX_ONE;
   endfunction

   function automatic logic [IDX_W-1:0] wrap_dec(input logic [IDX_W-1:0] i,
                                                 input logic [IDX_W-1:0] c);
      return (i == IDX_ONE) ? c : i - IDX_ONE;
   endfunction

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             dir;
   logic [TCW-1:0]   tick_cnt;
   logic             tick_pend;
   logic             tog_pend;
   logic [VAL_W-1:0] val_q;
   logic [1:0]       wcnt;
   logic             tick_run;
   logic             tick;
   logic             flip;
   logic [IDX_W-1:0] adj1, adj2, adj3, adv, idx_flip;
   logic [127:0]     line;

`ifdef SCROLL_PAUSE_EN
   logic paused;
   assign tick_run = (state != S_WAIT_RDY) && !paused;
`else
   assign tick_run = (state != S_WAIT_RDY);
`endif
   assign tick = tick_run && (tick_cnt == TICK_LAST);

   // A direction change re-centres idx three steps back so the new direction
   // continues from the line adjacent to what is already on screen.
   assign adj1     = dir ? wrap_inc(idx,  table_count) : wrap_dec(idx,  table_count);
   assign adj2     = dir ? wrap_inc(adj1, table_count) : wrap_dec(adj1, table_count);
   assign adj3     = dir ? wrap_inc(adj2, table_count) : wrap_dec(adj2, table_count);
   assign adv      = dir ? wrap_dec(idx,  table_count) : wrap_inc(idx,  table_count);
   assign flip     = dir_toggle ^ tog_pend;
   assign idx_flip = flip ? adj3 : idx;

   prime_line_fmt u_fmt (
      .idx  (8'(idx)),
      .val  (10'(val_q)),
      .line (line)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_WAIT_RDY;
         row_A     <= ROW_A_RST;
         row_B     <= ROW_B_RST;
         idx       <= IDX_ONE;
         dir       <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         busy      <= 1'b0;
         tick_cnt  <= '0;
         tick_pend <= 1'b0;
         tog_pend  <= 1'b0;
         val_q     <= '0;
         wcnt      <= '0;
`ifdef SCROLL_PAUSE_EN
         paused    <= 1'b0;
`endif
      end else begin
         rd_en <= 1'b0;
`ifdef SCROLL_PAUSE_EN
         if (pause_toggle) paused <= ~paused;
`endif
         if (tick_run) tick_cnt <= tick ? '0 : tick_cnt + TCW'(1);
         if (tick && state != S_IDLE) tick_pend <= 1'b1;
         if (dir_toggle && (state == S_READ || state == S_WAIT || state == S_COMMIT))
            tog_pend <= ~tog_pend;

         case (state)
            S_WAIT_RDY: begin
               if (dir_toggle) begin
                  dir <= ~dir;
                  idx <= adj3;
               end
               if (table_ready && table_count != '0) state <= S_IDLE;
            end
            S_IDLE: begin
               // Pending and fresh toggles combine, and apply before a same-cycle tick.
               if (flip) begin
                  dir <= ~dir;
                  idx <= adj3;
               end
               tog_pend <= 1'b0;
               if (tick || tick_pend) begin
                  tick_pend <= 1'b0;
                  rd_en     <= 1'b1;
                  rd_addr   <= idx_flip;
                  busy      <= 1'b1;
                  state     <= S_READ;
               end
            end
            S_READ: begin
               wcnt  <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (wcnt == WAIT_LAST) begin
                  val_q <= rd_data;
                  state <= S_COMMIT;
               end else begin
                  wcnt <= wcnt + 2'd1;
               end
            end
            S_COMMIT: begin
               if (dir) begin
                  row_A <= line;
                  row_B <= row_A;
               end else begin
                  row_A <= row_B;
                  row_B <= line;
               end
               idx   <= adv;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_WAIT_RDY;
         endcase
      end
   end

endmodule
